// File: rtl/dm_banked_lsu.sv
// Data memory for the MEM stage: byte/half/word loads and stores with sign/zero
// extension, misalignment detection and a req/ready/done handshake with wait states.
module dm_banked_lsu #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              ready,
  output logic              done,
  output logic [31:0]       rdata,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshake: a request is accepted on a rising edge where ready=1 and req=1;
  // done pulses for one cycle WAIT_CYCLES+1 cycles later, ready returns the cycle after.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic       NO_WAIT   = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam int         IDX_W     = ADDR_W - 2;

  state_t              state;
  logic [3:0]          cnt;
  logic                l_we;
  logic [1:0]          l_size;
  logic                l_sign;
  logic [ADDR_W-1:0]   l_addr;
  logic [31:0]         l_wdata;

  logic [31:0]         mem [DEPTH_WORDS];

  logic                a_we;
  logic [1:0]          a_size;
  logic                a_sign;
  logic [ADDR_W-1:0]   a_addr;
  logic [31:0]         a_wdata;
  logic [IDX_W-1:0]    a_idx;
  logic                access;
  logic                misalign;
  logic [3:0]          be;
  logic [31:0]         wd_lanes;
  logic [31:0]         word;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_half;
  logic [31:0]         ld_val;

  assign dbg_state = state;

  // With no wait states the access happens on the accept edge itself, so the
  // live inputs are used; otherwise the latched request drives the access.
  always_comb begin
    a_we    = l_we;
    a_size  = l_size;
    a_sign  = l_sign;
    a_addr  = l_addr;
    a_wdata = l_wdata;
    if (state == S_IDLE) begin
      a_we    = we;
      a_size  = size;
      a_sign  = sign;
      a_addr  = addr;
      a_wdata = wdata;
    end
  end

  assign a_idx  = a_addr[ADDR_W-1:2];
  assign access = rst_n &&
                  ((NO_WAIT && state == S_IDLE && req) ||
                   (state == S_WAIT && cnt == 4'd0));

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    wd_lanes = a_wdata;
    case (a_size)
      2'b00: begin
        be       = 4'b0001 << a_addr[1:0];
        wd_lanes = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        misalign = a_addr[0];
        be       = a_addr[1] ? 4'b1100 : 4'b0011;
        wd_lanes = {2{a_wdata[15:0]}};
      end
      2'b10: begin
        misalign = (a_addr[1:0] != 2'b00);
        be       = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  always_comb begin
    word    = mem[a_idx];
    ld_byte = word[{a_addr[1:0], 3'b000} +: 8];
    ld_half = a_addr[1] ? word[31:16] : word[15:0];
    case (a_size)
      2'b00:   ld_val = {{24{a_sign & ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = {{16{a_sign & ld_half[15]}}, ld_half};
      default: ld_val = word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (access && a_we && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[a_idx][8*b +: 8] <= wd_lanes[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      ready   <= 1'b1;
      done    <= 1'b0;
      rdata   <= 32'd0;
      err     <= 1'b0;
      l_we    <= 1'b0;
      l_size  <= 2'b00;
      l_sign  <= 1'b0;
      l_addr  <= '0;
      l_wdata <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            l_we    <= we;
            l_size  <= size;
            l_sign  <= sign;
            l_addr  <= addr;
            l_wdata <= wdata;
            ready   <= 1'b0;
            if (NO_WAIT) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) state <= S_RESP;
          else             cnt   <= cnt - 4'd1;
        end
        S_RESP: begin
          state <= S_IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
          err   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
      // Stores leave rdata untouched; faulting accesses return zero.
      if (access) begin
        done <= 1'b1;
        err  <= misalign;
        if (misalign)   rdata <= 32'd0;
        else if (!a_we) rdata <= ld_val;
      end
    end
  end

endmodule

// File: tb/tb_dm_banked_lsu.sv
// Bench for dm_banked_lsu: one instance without wait states, one with three,
// table vectors, handshake corner sequences and random traffic against a byte model.
module tb_dm_banked_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_s   [2];
  logic        we_s    [2];
  logic [1:0]  size_s  [2];
  logic        sign_s  [2];
  logic [11:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic        ready_s [2];
  logic        done_s  [2];
  logic [31:0] rdata_s [2];
  logic        err_s   [2];
  logic [1:0]  dbg_s   [2];

  int passed;
  int total;

  logic [7:0]  mb [2][4096];
  logic [31:0] exp_q [$];

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [18];

  dm_banked_lsu #(.DEPTH_WORDS(1024), .ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_s[0]), .we(we_s[0]), .size(size_s[0]),
    .sign(sign_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]), .ready(ready_s[0]),
    .done(done_s[0]), .rdata(rdata_s[0]), .err(err_s[0]), .dbg_state(dbg_s[0])
  );

  dm_banked_lsu #(.DEPTH_WORDS(1024), .ADDR_W(12), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_s[1]), .we(we_s[1]), .size(size_s[1]),
    .sign(sign_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]), .ready(ready_s[1]),
    .done(done_s[1]), .rdata(rdata_s[1]), .err(err_s[1]), .dbg_state(dbg_s[1])
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got=%h required=%h", nm, got, exp);
  endtask

  // Reference model: memory as a little-endian byte array.
  function automatic void model_access(input int i, input logic w, input logic [1:0] sz,
                                       input logic sg, input logic [11:0] a,
                                       input logic [31:0] wd,
                                       output logic [31:0] er, output logic ee);
    int n;
    logic [31:0] val;
    n  = 1 << sz;
    ee = (sz == 2'b11) || ((int'(a) % n) != 0);
    er = 32'd0;
    if (ee) return;
    if (w) begin
      for (int k = 0; k < n; k++) mb[i][int'(a) + k] = 8'(wd >> (8 * k));
    end else begin
      val = 32'd0;
      for (int k = 0; k < n; k++) val = val | (32'(mb[i][int'(a) + k]) << (8 * k));
      if (sg && n < 4 && val[8 * n - 1]) val = val | ~((32'd1 << (8 * n)) - 32'd1);
      er = val;
    end
  endfunction

  // driver: one complete access, checked for latency, err, rdata and pulse shape
  task automatic do_access(input int i, input logic w, input logic [1:0] sz, input logic sg,
                           input logic [11:0] a, input logic [31:0] wd,
                           input logic [31:0] er, input logic ee, input logic chk_r,
                           input string nm);
    int n;
    logic [31:0] exp_r;
    n = 0;
    while (!ready_s[i] && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({nm, " ready_before"}, 32'(ready_s[i]), 32'd1);
    req_s[i]   = 1'b1;
    we_s[i]    = w;
    size_s[i]  = sz;
    sign_s[i]  = sg;
    addr_s[i]  = a;
    wdata_s[i] = wd;
    exp_q.push_back(er);
    @(posedge clk); #1;
    req_s[i]   = 1'b0;
    we_s[i]    = 1'($urandom);
    size_s[i]  = 2'($urandom);
    sign_s[i]  = 1'($urandom);
    addr_s[i]  = 12'($urandom);
    wdata_s[i] = $urandom;
    n = 0;
    while (!done_s[i] && n < 40) begin
      @(posedge clk); #1; n++;
    end
    exp_r = exp_q.pop_front();
    check({nm, " done_seen"}, 32'(done_s[i]), 32'd1);
    check({nm, " latency"}, 32'(n), (i == 1) ? 32'd3 : 32'd0);
    check({nm, " err"}, 32'(err_s[i]), 32'(ee));
    if (chk_r) check({nm, " rdata"}, rdata_s[i], exp_r);
    @(posedge clk); #1;
    check({nm, " done_pulse_end"}, 32'(done_s[i]), 32'd0);
    check({nm, " ready_after"}, 32'(ready_s[i]), 32'd1);
  endtask

  initial begin
    logic [31:0] er;
    logic        ee;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [11:0] a;
    logic [31:0] wd;

    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 1'b0; we_s[i] = 1'b0; size_s[i] = 2'b00; sign_s[i] = 1'b0;
      addr_s[i] = 12'h0; wdata_s[i] = 32'h0;
    end

    vecs[0]  = '{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'd2, 1'b0, 12'h020, 32'h80FF7F01, 32'h00000000, 1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 12'h023, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 12'h023, 32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 12'h022, 32'h0,        32'hFFFF80FF, 1'b0};
    vecs[6]  = '{1'b1, 2'd0, 1'b0, 12'h021, 32'h123456AA, 32'h00000000, 1'b0};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 12'h020, 32'h0,        32'h80FFAA01, 1'b0};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 12'h012, 32'h12345678, 32'h00000000, 1'b1};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h0,        32'hDEADBEEF, 1'b0};
    vecs[10] = '{1'b0, 2'd1, 1'b0, 12'h011, 32'h0,        32'h00000000, 1'b1};
    vecs[11] = '{1'b0, 2'd3, 1'b0, 12'h010, 32'h0,        32'h00000000, 1'b1};
    vecs[12] = '{1'b1, 2'd1, 1'b0, 12'h042, 32'h5555BEEF, 32'h00000000, 1'b0};
    vecs[13] = '{1'b0, 2'd1, 1'b0, 12'h042, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 12'hFFC, 32'hCAFEF00D, 32'h00000000, 1'b0};
    vecs[15] = '{1'b0, 2'd2, 1'b1, 12'hFFC, 32'h0,        32'hCAFEF00D, 1'b0};
    vecs[16] = '{1'b0, 2'd1, 1'b1, 12'h020, 32'h0,        32'hFFFFAA01, 1'b0};
    vecs[17] = '{1'b0, 2'd0, 1'b0, 12'h021, 32'h0,        32'h000000AA, 1'b0};

    // reset state, during and after reset
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst ready", 32'(ready_s[i]), 32'd1);
      check("rst done", 32'(done_s[i]), 32'd0);
      check("rst rdata", rdata_s[i], 32'd0);
      check("rst err", 32'(err_s[i]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) check("post_rst ready", 32'(ready_s[i]), 32'd1);

    // table vectors on both instances
    for (int i = 0; i < 2; i++) begin
      for (int v = 0; v < 18; v++) begin
        model_access(i, vecs[v].we, vecs[v].size, vecs[v].sign, vecs[v].addr,
                     vecs[v].wdata, er, ee);
        do_access(i, vecs[v].we, vecs[v].size, vecs[v].sign, vecs[v].addr, vecs[v].wdata,
                  vecs[v].exp_rdata, vecs[v].exp_err, !vecs[v].we || vecs[v].exp_err,
                  $sformatf("vec%0d_dut%0d", v, i));
      end
    end

    // req held high through busy cycles: exactly two accesses in ten cycles
    req_s[1] = 1'b1; we_s[1] = 1'b0; size_s[1] = 2'd2; sign_s[1] = 1'b0;
    addr_s[1] = 12'h010; wdata_s[1] = 32'h0;
    @(posedge clk); #1;
    for (int k = 1; k <= 10; k++) begin
      check($sformatf("hold k%0d ready", k), 32'(ready_s[1]), 32'((k == 5) || (k == 10)));
      check($sformatf("hold k%0d done", k), 32'(done_s[1]), 32'((k == 4) || (k == 9)));
      if (k == 4 || k == 9) check($sformatf("hold k%0d rdata", k), rdata_s[1], 32'hDEADBEEF);
      if (k == 10) req_s[1] = 1'b0;
      else begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    check("hold no_third", 32'(ready_s[1]), 32'd1);

    // reset in the WAIT state of a store: the store must not land
    model_access(1, 1'b1, 2'd2, 1'b0, 12'h030, 32'h11111111, er, ee);
    do_access(1, 1'b1, 2'd2, 1'b0, 12'h030, 32'h11111111, 32'h0, 1'b0, 1'b0, "rst_pre_store");
    req_s[1] = 1'b1; we_s[1] = 1'b1; size_s[1] = 2'd2; addr_s[1] = 12'h030;
    wdata_s[1] = 32'h22222222;
    @(posedge clk); #1;
    req_s[1] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid ready", 32'(ready_s[1]), 32'd1);
    check("rst_mid done", 32'(done_s[1]), 32'd0);
    check("rst_mid state", 32'(dbg_s[1]), 32'd0);
    @(posedge clk); #1;
    check("rst_mid done_held", 32'(done_s[1]), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_access(1, 1'b0, 2'd2, 1'b0, 12'h030, 32'h0, er, ee);
    do_access(1, 1'b0, 2'd2, 1'b0, 12'h030, 32'h0, er, ee, 1'b1, "rst_old_value");

    // random traffic against the byte model
    for (int i = 0; i < 2; i++) begin
      for (int wi = 0; wi < 64; wi++) begin
        wd = $urandom;
        model_access(i, 1'b1, 2'd2, 1'b0, 12'(wi * 4), wd, er, ee);
        do_access(i, 1'b1, 2'd2, 1'b0, 12'(wi * 4), wd, er, ee, 1'b0, "init");
      end
      for (int r = 0; r < 80; r++) begin
        w  = 1'($urandom);
        sz = 2'($urandom_range(0, 3));
        sg = 1'($urandom);
        a  = 12'($urandom_range(0, 255));
        wd = $urandom;
        model_access(i, w, sz, sg, a, wd, er, ee);
        do_access(i, w, sz, sg, a, wd, er, ee, !w || ee, $sformatf("rand%0d_dut%0d", r, i));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dm_banked_lsu.md
Name: dm_banked_lsu

Overview:
- Parametrised data memory for the pipeline CPU MEM stage.
- Successor of the 4 KB byte/word data memory: configurable depth, byte/halfword/word loads and stores, sign or zero extension, misalignment detection.
- Registered read path and a request/ready/done handshake with programmable wait states.
- Used with the stall logic so slower memories can be modelled without changing the core.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; power of two, minimum 4.
- ADDR_W, 12: byte-address width; must equal log2(DEPTH_WORDS)+2.
- WAIT_CYCLES, 0: extra cycles between accept and completion; range 0..15.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 1: access request; sampled when ready=1.
- we, input, 1: 1 = store, 0 = load.
- size, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
- sign, input, 1: 1 = sign-extend byte/half loads, 0 = zero-extend.
- addr, input, ADDR_W: byte address.
- wdata, input, 32: store data, taken from the low bits (byte [7:0], half [15:0]).
- ready, output, 1: block idle, can accept req.
- done, output, 1: one-cycle completion pulse.
- rdata, output, 32: load result; valid when done=1 and the access was a load.
- err, output, 1: qualified by done; misaligned or illegal access.

Behaviour:
- Reset, asynchronous and active-low:
  - state = IDLE; ready=1, done=0, rdata=0, err=0; wait counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - ready=1.
  - On req=1, latch we/size/sign/addr/wdata.
  - Next state is WAIT (counter loaded with WAIT_CYCLES-1) if WAIT_CYCLES>0, otherwise RESP.
- WAIT:
  - ready=0; the counter decrements each cycle.
  - Move to RESP on the edge where the counter is 0.
- Access edge (the edge that enters RESP):
  - Stores write RAM with the latched request; loads capture rdata.
- RESP:
  - done=1 for exactly one cycle, ready=0; next state IDLE.
  - Outside RESP: done=0, rdata holds its last value, err=0.
- Total latency from accept edge to done: WAIT_CYCLES+1 cycles.
- Accept-to-accept throughput: one access per WAIT_CYCLES+2 cycles.
- Lanes are little-endian; word index = addr[ADDR_W-1:2].
  - Byte: lane addr[1:0].
  - Half: lane addr[1] (bits [15:0] or [31:16]).
- Store write masks:
  - Byte: only the selected 8 bits change.
  - Half: only the selected 16 bits change.
  - Word: all 32 bits change.
- Load extension:
  - Byte: bits [31:8] = sign ? bit7 : 0.
  - Half: bits [31:16] = sign ? bit15 : 0.
  - Word: the sign input is ignored.
- Misaligned/illegal access (half with addr[0]=1, word with addr[1:0]!=0, or size=11):
  - No RAM write; rdata=0; err=1 with done.
  - Latency is the same as a legal access.
- req while ready=0 is ignored (not queued); the core must hold req until it sees ready.
- Request inputs are latched at accept; later changes during WAIT have no effect.
- Store followed immediately by a load to the same word: the load returns the updated data.
- Address wrap: addresses beyond DEPTH_WORDS*4 are impossible because ADDR_W is bounded; the top word index DEPTH_WORDS-1 is accessible.
- Reset asserted mid-access:
  - The FSM returns to IDLE immediately; done is never pulsed.
  - Before the access edge: the store does not occur.
  - After the access edge: the write stands.

Test Plan:
- WAIT_CYCLES=0: store word 0xDEADBEEF @0x010, then load word @0x010 -> done 1 cycle after each accept, rdata=0xDEADBEEF, err=0.
- Byte/half lanes:
  - After word 0x80FF7F01 @0x020, load byte @0x023 sign=1 -> 0xFFFFFF80; sign=0 -> 0x00000080.
  - Load half @0x022 sign=1 -> 0xFFFF80FF.
  - Store byte 0xAA @0x021 then load word -> 0x80FFAA01.
- Misalign: store word @0x012 data 0x12345678 -> err=1, rdata=0; a subsequent load word @0x010 returns the prior contents unchanged. size=11 -> err=1.
- WAIT_CYCLES=3:
  - Accept at cycle 0 -> ready low cycles 1-4, done at cycle 4, ready high at cycle 5.
  - req held high during busy cycles does not create extra accesses.
- Back-to-back: store half 0xBEEF @0x042 accepted on the cycle ready returns, then load half @0x042 sign=0 -> 0x0000BEEF, with no stale data.
- Reset mid-access (WAIT_CYCLES=3): assert rst_n=0 in the WAIT state of a store to @0x030 -> ready=1, done=0 immediately; a later load @0x030 shows the old value.
